// File: rtl/timer_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
package timer_pkg;

   localparam int unsigned TICK_DIV_DEF = 100_000_000;
   localparam int unsigned BCD_W        = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PAUSE   = 2'd1,
      ST_EXPIRED = 2'd2
   } state_e;

endpackage

// File: rtl/bcd_down_digit.sv
// Single BCD digit: synchronous load, decrement with 0 -> 9 wrap and borrow-out.
module bcd_down_digit
   import timer_pkg::*;
#(
   parameter logic [BCD_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [BCD_W-1:0] load_val,
   input  logic             dec,
   output logic [BCD_W-1:0] digit,
   output logic             borrow_c
);

   logic [BCD_W-1:0] digit_q, digit_d;

   always_comb begin
      digit_d = digit_q;
      if (load) begin
         digit_d = load_val;
      end else if (dec) begin
         digit_d = (digit_q == '0) ? BCD_MAX : digit_q - BCD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) digit_q <= RST_VAL;
      else      digit_q <= digit_d;
   end

   assign digit    = digit_q;
   assign borrow_c = dec && !load && (digit_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD seconds countdown with run/pause/expired FSM and prescaler.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the preset one cycle after expiry.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
   parameter int unsigned PRESET_TENS = 3,
   parameter int unsigned PRESET_ONES = 0,
   parameter int unsigned DIV_W       = 27
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             count_en,
   input  logic             load,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones,
   output logic             tick,
   output logic             done
);

   localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(TICK_DIV - 1);
   localparam logic [BCD_W-1:0] PRE_T     = BCD_W'(PRESET_TENS);
   localparam logic [BCD_W-1:0] PRE_O     = BCD_W'(PRESET_ONES);
   localparam bit               PRE_ZERO  = (PRESET_TENS == 0) && (PRESET_ONES == 0);
   localparam state_e           RST_STATE = PRE_ZERO ? ST_EXPIRED : ST_RUN;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic             tick_q, tick_d;
   logic             done_q, done_d;
   logic             step;
   logic             digit_load;
   logic             ones_borrow;
   logic             unused_tens_borrow;
   logic             last;
   state_e           resume_state;

   assign last         = (tens == '0) && (ones == BCD_W'(1));
   assign resume_state = count_en ? ST_RUN : ST_PAUSE;

   // Next state; the run level takes effect on the edge it is sampled, so a
   // resume edge already advances the prescaler.
   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      tick_d     = 1'b0;
      done_d     = done_q;
      step       = 1'b0;
      digit_load = 1'b0;
      if (load) begin
         digit_load = 1'b1;
         presc_d    = '0;
         done_d     = PRE_ZERO;
         state_d    = PRE_ZERO ? ST_EXPIRED : resume_state;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (presc_q == PRESC_MAX) begin
                  step    = 1'b1;
                  tick_d  = 1'b1;
                  presc_d = '0;
                  if (last) begin
                     state_d = ST_EXPIRED;
                     done_d  = 1'b1;
                  end else if (!count_en) begin
                     state_d = ST_PAUSE;
                  end
               end else if (count_en) begin
                  presc_d = presc_q + DIV_W'(1);
               end else begin
                  state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (count_en) begin
                  state_d = ST_RUN;
                  presc_d = presc_q + DIV_W'(1);
               end
            end
            ST_EXPIRED: begin
               presc_d = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
               digit_load = 1'b1;
               done_d     = PRE_ZERO;
               state_d    = PRE_ZERO ? ST_EXPIRED : resume_state;
`endif
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RST_STATE;
         presc_q <= '0;
         tick_q  <= 1'b0;
         done_q  <= PRE_ZERO;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
      end
   end

   // Ones borrow gates the tens decrement.
   bcd_down_digit #(.RST_VAL(PRE_O)) u_ones (
      .clk      (clk),
      .rst      (rst),
      .load     (digit_load),
      .load_val (PRE_O),
      .dec      (step),
      .digit    (ones),
      .borrow_c (ones_borrow)
   );

   bcd_down_digit #(.RST_VAL(PRE_T)) u_tens (
      .clk      (clk),
      .rst      (rst),
      .load     (digit_load),
      .load_val (PRE_T),
      .dec      (ones_borrow),
      .digit    (tens),
      .borrow_c (unused_tens_borrow)
   );

   assign tick = tick_q;
   assign done = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (TICK_DIV=4, presets 03 and 10).
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       rst;
   logic       count_en;
   logic       load;
   logic       load10;
   logic [3:0] tens, ones, tens10, ones10;
   logic       tick, done, tick10, done10;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   countdown_timer #(.TICK_DIV(4), .PRESET_TENS(0), .PRESET_ONES(3), .DIV_W(3)) u_dut (
      .clk(clk), .rst(rst), .count_en(count_en), .load(load),
      .tens(tens), .ones(ones), .tick(tick), .done(done)
   );

   countdown_timer #(.TICK_DIV(4), .PRESET_TENS(1), .PRESET_ONES(0), .DIV_W(3)) u_dut10 (
      .clk(clk), .rst(rst), .count_en(count_en), .load(load10),
      .tens(tens10), .ones(ones10), .tick(tick10), .done(done10)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Packed view {tens, ones, tick, done} of the preset-03 instance.
   task automatic expect_out(input string tag, input logic [3:0] t, input logic [3:0] o,
                             input logic tk, input logic dn);
      check(tag, 32'({tens, ones, tick, done}), 32'({t, o, tk, dn}));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] ones_at(input int k);
      if (k < 4)       return 4'd3;
      else if (k < 8)  return 4'd2;
      else if (k < 12) return 4'd1;
      else             return 4'd0;
   endfunction

   initial begin
      int k;
      logic exp_tick, exp_done;

      rst = 1'b0; count_en = 1'b0; load = 1'b0; load10 = 1'b0;
      cyc(2);
      expect_out("reset", 4'd0, 4'd3, 1'b0, 1'b0);
      check("reset_p10", 32'({tens10, ones10, tick10, done10}), 32'({4'd1, 4'd0, 2'b00}));

      // Free run from reset release; ticks at cycles 4, 8, 12.
      rst = 1'b1; count_en = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         cyc(1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         k        = c % 13;
         exp_tick = (k == 4) || (k == 8) || (k == 12);
         exp_done = (k == 12);
`else
         k        = c;
         exp_tick = (c == 4) || (c == 8) || (c == 12);
         exp_done = (c >= 12);
`endif
         expect_out($sformatf("run_c%0d", c), 4'd0, ones_at(k), exp_tick, exp_done);
         if (c == 4)
            check("borrow_p10", 32'({tens10, ones10, tick10}), 32'({4'd0, 4'd9, 1'b1}));
         if (c == 5)
            check("borrow_p10_hold", 32'({tens10, ones10, tick10}), 32'({4'd0, 4'd9, 1'b0}));
      end

      // Load restarts the count; first step four edges later.
      load = 1'b1;
      cyc(1);
      load = 1'b0;
      expect_out("load_restart", 4'd0, 4'd3, 1'b0, 1'b0);
      cyc(3);
      expect_out("load_pre_step", 4'd0, 4'd3, 1'b0, 1'b0);
      cyc(1);
      expect_out("load_first_step", 4'd0, 4'd2, 1'b1, 1'b0);

      // Asynchronous reset at digits 02.
      rst = 1'b0;
      #1;
      expect_out("async_reset", 4'd0, 4'd3, 1'b0, 1'b0);
      cyc(1);
      rst = 1'b1;

      // Pause with prescaler at 2 for ten edges, then resume.
      cyc(2);
      count_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         expect_out($sformatf("paused_%0d", i), 4'd0, 4'd3, 1'b0, 1'b0);
      end
      count_en = 1'b1;
      cyc(1);
      expect_out("resume_1", 4'd0, 4'd3, 1'b0, 1'b0);
      cyc(1);
      expect_out("resume_2", 4'd0, 4'd2, 1'b1, 1'b0);

      // Load while paused at digits 01.
      cyc(3);
      expect_out("pre_01", 4'd0, 4'd2, 1'b0, 1'b0);
      cyc(1);
      expect_out("at_01", 4'd0, 4'd1, 1'b1, 1'b0);
      count_en = 1'b0; load = 1'b1;
      cyc(1);
      load = 1'b0;
      expect_out("load_paused", 4'd0, 4'd3, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         expect_out($sformatf("load_hold_%0d", i), 4'd0, 4'd3, 1'b0, 1'b0);
      end
      count_en = 1'b1;
      cyc(3);
      expect_out("load_resume_pre", 4'd0, 4'd3, 1'b0, 1'b0);
      cyc(1);
      expect_out("load_resume_step", 4'd0, 4'd2, 1'b1, 1'b0);

      // Load on the wrap edge wins; prescaler restarts from 0.
      cyc(3);
      expect_out("pre_wrap", 4'd0, 4'd2, 1'b0, 1'b0);
      load = 1'b1;
      cyc(1);
      load = 1'b0;
      expect_out("load_on_wrap", 4'd0, 4'd3, 1'b0, 1'b0);
      cyc(3);
      expect_out("after_wrap_load", 4'd0, 4'd3, 1'b0, 1'b0);
      cyc(1);
      expect_out("after_wrap_step", 4'd0, 4'd2, 1'b1, 1'b0);

      // count_en falling on the wrap edge still steps, then holds.
      cyc(3);
      count_en = 1'b0;
      cyc(1);
      expect_out("step_on_pause", 4'd0, 4'd1, 1'b1, 1'b0);
      cyc(3);
      expect_out("pause_after_step", 4'd0, 4'd1, 1'b0, 1'b0);

      // Resume into expiry from 01.
      count_en = 1'b1;
      cyc(4);
      expect_out("expire", 4'd0, 4'd0, 1'b1, 1'b1);
      cyc(1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      expect_out("post_expire", 4'd0, 4'd3, 1'b0, 1'b0);
`else
      expect_out("post_expire", 4'd0, 4'd0, 1'b0, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
